// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the MAR/MDR memory-access stage: FSM state codes,
// size/direction encodings and the byte sign-extension helper.
package mem_access_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic DATA_SIZE_BYTE = 1'b0;
  localparam logic DATA_SIZE_WORD = 1'b1;
  localparam logic RW_READ        = 1'b0;
  localparam logic RW_WRITE       = 1'b1;

  function automatic logic signed [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational LC-3b byte/word lane logic: write-byte replication into MDR,
// byte write-enable decode and sign-extended byte select for the bus.
module mem_byte_lane
  import mem_access_ctrl_pkg::*;
(
  input  logic        data_size_i,
  input  logic        r_w_i,
  input  logic        active_i,
  input  logic        mar0_i,
  input  logic [15:0] bus_in_i,
  input  logic [15:0] mdr_i,
  output logic [15:0] bus_wdata_o,
  output logic [15:0] bus_out_o,
  output logic [1:0]  mem_we_o
);

  logic [7:0] rd_byte;

  always_comb begin
    bus_wdata_o = (data_size_i == DATA_SIZE_WORD) ? bus_in_i : {bus_in_i[7:0], bus_in_i[7:0]};
    rd_byte     = mar0_i ? mdr_i[15:8] : mdr_i[7:0];
    bus_out_o   = (data_size_i == DATA_SIZE_WORD) ? mdr_i : sext8(rd_byte);
    mem_we_o    = 2'b00;
    if (active_i && (r_w_i == RW_WRITE)) begin
      if (data_size_i == DATA_SIZE_WORD) mem_we_o = 2'b11;
      else                               mem_we_o = mar0_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory-access stage with a fixed-latency memory cycle and R pulse.
// Optional odd-address word trap enabled by defining MEM_UNALIGNED_TRAP_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_mar_i,
  input  logic        ld_mdr_i,
  input  logic        mio_en_i,
  input  logic        r_w_i,
  input  logic        data_size_i,
  input  logic [15:0] addr_in_i,
  input  logic [15:0] bus_in_i,
  output logic [15:0] mar_out_o,
  output logic [15:0] bus_out_o,
  output logic        r_o,
  output logic        unaligned_o,
  output logic        mem_en_o,
  output logic [1:0]  mem_we_o,
  output logic [14:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 3);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      mar_q, mar_d;
  logic [15:0]      mdr_q, mdr_d;
  logic [15:0]      bus_wdata;
  logic             trap;

`ifdef MEM_UNALIGNED_TRAP_EN
  // The trap looks at the address the access will actually use, including a same-edge MAR load.
  logic eff_mar0;
  assign eff_mar0    = ld_mar_i ? addr_in_i[0] : mar_q[0];
  assign trap        = (data_size_i == DATA_SIZE_WORD) && eff_mar0;
  assign unaligned_o = (state_q == ST_FAULT);
`else
  assign trap        = 1'b0;
  assign unaligned_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mio_en_i) begin
          state_d = trap ? ST_FAULT : ST_ACCESS;
          cnt_d   = CNT_INIT;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mar_d = mar_q;
    if (ld_mar_i && (state_q != ST_ACCESS)) mar_d = addr_in_i;
    mdr_d = mdr_q;
    if (ld_mdr_i) begin
      if (!mio_en_i)                mdr_d = bus_wdata;
      else if (state_q == ST_DONE) mdr_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  assign mem_en_o    = (state_q == ST_ACCESS) || (state_q == ST_DONE);
  assign r_o         = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign mar_out_o   = mar_q;
  assign mem_addr_o  = mar_q[15:1];
  assign mem_wdata_o = mdr_q;

  mem_byte_lane u_lane (
    .data_size_i (data_size_i),
    .r_w_i       (r_w_i),
    .active_i    (mem_en_o),
    .mar0_i      (mar_q[0]),
    .bus_in_i    (bus_in_i),
    .mdr_i       (mdr_q),
    .bus_wdata_o (bus_wdata),
    .bus_out_o   (bus_out_o),
    .mem_we_o    (mem_we_o)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_mar, ld_mdr, mio_en, r_w, data_size;
  logic [15:0] addr_in, bus_in, mem_rdata;
  logic [15:0] mar_out, bus_out, mem_wdata;
  logic        r, unaligned, mem_en;
  logic [1:0]  mem_we;
  logic [14:0] mem_addr;

  int checks = 0;
  int errors = 0;

`ifdef MEM_UNALIGNED_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  mem_access_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ld_mar_i(ld_mar), .ld_mdr_i(ld_mdr), .mio_en_i(mio_en),
    .r_w_i(r_w), .data_size_i(data_size), .addr_in_i(addr_in), .bus_in_i(bus_in),
    .mar_out_o(mar_out), .bus_out_o(bus_out), .r_o(r), .unaligned_o(unaligned),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_sext(input logic [7:0] b);
    return (b >= 8'd128) ? (16'hFF00 | 16'(b)) : 16'(b);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; data_size = 1;
    addr_in = 0; bus_in = 0; mem_rdata = 0;
    #2;
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL reset_r got %0b exp 0", r); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b exp 0", mem_en); end
    checks++; if (mem_we !== 2'b00) begin errors++; $display("FAIL reset_mem_we got %b exp 00", mem_we); end
    checks++; if (unaligned !== 1'b0) begin errors++; $display("FAIL reset_unaligned got %0b exp 0", unaligned); end
    checks++; if (mar_out !== 16'h0) begin errors++; $display("FAIL reset_mar got %h exp 0000", mar_out); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mdr got %h exp 0000", mem_wdata); end
    #2 rst_n = 1'b1;
    step();
  endtask

  // Word read at 3000 with LD_MAR and MIO_EN in the same IDLE cycle.
  task automatic test_read_latency();
    for (int c = 1; c <= 7; c++) begin
      ld_mar = (c == 1); addr_in = 16'h3000; r_w = 0; data_size = 1;
      mio_en = (c == 1) || (c == LAT); ld_mdr = (c == LAT);
      mem_rdata = (c == LAT) ? 16'hBEEF : 16'h1111;
      checks++; if (mem_en !== (c >= 2 && c <= LAT)) begin errors++; $display("FAIL lat_mem_en cyc %0d got %0b", c, mem_en); end
      checks++; if (r !== (c == LAT)) begin errors++; $display("FAIL lat_r cyc %0d got %0b", c, r); end
      if (c >= 2 && c <= LAT) begin
        checks++; if (mem_addr !== 15'h1800) begin errors++; $display("FAIL lat_addr got %h exp 1800", mem_addr); end
        checks++; if (mem_we !== 2'b00) begin errors++; $display("FAIL lat_we got %b exp 00", mem_we); end
      end
      step();
    end
    checks++; if (bus_out !== 16'hBEEF) begin errors++; $display("FAIL lat_bus_out got %h exp BEEF", bus_out); end
  endtask

  task automatic test_byte_read();
    ld_mar = 1; addr_in = 16'h3001; ld_mdr = 1; bus_in = 16'h8012; data_size = 1; mio_en = 0;
    step();
    ld_mar = 0; ld_mdr = 0; data_size = 0; #1;
    checks++; if (bus_out !== 16'hFF80) begin errors++; $display("FAIL byte_hi got %h exp FF80", bus_out); end
    ld_mar = 1; addr_in = 16'h3000;
    step();
    ld_mar = 0; #1;
    checks++; if (bus_out !== 16'h0012) begin errors++; $display("FAIL byte_lo got %h exp 0012", bus_out); end
  endtask

  task automatic test_byte_write();
    ld_mar = 1; addr_in = 16'h4001; ld_mdr = 1; bus_in = 16'h00A5; data_size = 0; r_w = 1; mio_en = 0;
    step();
    ld_mar = 0; ld_mdr = 0;
    checks++; if (mem_wdata !== 16'hA5A5) begin errors++; $display("FAIL bw_mdr got %h exp A5A5", mem_wdata); end
    checks++; if (mem_addr !== 15'h2000) begin errors++; $display("FAIL bw_addr got %h exp 2000", mem_addr); end
    mio_en = 1;
    for (int c = 1; c <= LAT + 1; c++) begin
      checks++; if (mem_we !== ((c >= 2 && c <= LAT) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL bw_we cyc %0d got %b", c, mem_we); end
      step();
      mio_en = 0;
    end
    r_w = 0;
  endtask

  task automatic test_freeze();
    ld_mar = 1; addr_in = 16'h3000; data_size = 1; r_w = 0; mio_en = 1;
    step();
    ld_mar = 0; mio_en = 0;
    step();
    ld_mar = 1; addr_in = 16'h5000;
    step();
    ld_mar = 0;
    checks++; if (mar_out !== 16'h3000) begin errors++; $display("FAIL freeze_mar got %h exp 3000", mar_out); end
    for (int c = 0; c < LAT; c++) step();
  endtask

  task automatic test_reset_mid();
    ld_mar = 1; addr_in = 16'h3000; mio_en = 1; data_size = 1; r_w = 0;
    step();
    ld_mar = 0; mio_en = 0;
    step();
    rst_n = 1'b0; #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_mem_en got %0b exp 0", mem_en); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL rstmid_r got %0b exp 0", r); end
    #2 rst_n = 1'b1;
    for (int c = 0; c < LAT; c++) begin
      step();
      checks++; if (mem_en !== 1'b0 || r !== 1'b0) begin errors++; $display("FAIL rstmid_idle got en=%0b r=%0b exp 0/0", mem_en, r); end
    end
  endtask

  task automatic test_unaligned();
    ld_mar = 1; addr_in = 16'h3001; mio_en = 1; data_size = 1; r_w = 0;
    step();
    ld_mar = 0; mio_en = 0;
    if (TRAP_ON) begin
      checks++; if (r !== 1'b1 || unaligned !== 1'b1) begin errors++; $display("FAIL trap got r=%0b u=%0b exp 1/1", r, unaligned); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL trap_mem_en got %0b exp 0", mem_en); end
      step();
      checks++; if (r !== 1'b0 || unaligned !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL trap_after got r=%0b u=%0b en=%0b", r, unaligned, mem_en); end
    end else begin
      checks++; if (mem_en !== 1'b1 || unaligned !== 1'b0) begin errors++; $display("FAIL notrap got en=%0b u=%0b exp 1/0", mem_en, unaligned); end
      checks++; if (mem_addr !== 15'h1800) begin errors++; $display("FAIL notrap_addr got %h exp 1800", mem_addr); end
      for (int c = 2; c < LAT; c++) step();
      checks++; if (r !== 1'b1) begin errors++; $display("FAIL notrap_r got %0b exp 1", r); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    ld_mar = 1; addr_in = 16'h2000; data_size = 1; r_w = 0;
    step();
    ld_mar = 0;
    for (int c = 1; c <= 12; c++) begin
      mio_en = (c <= 2 * LAT);
      checks++; if (mem_en !== ((c >= 2 && c <= LAT) || (c >= LAT + 2 && c <= 2 * LAT))) begin errors++; $display("FAIL b2b_en cyc %0d got %0b", c, mem_en); end
      checks++; if (r !== (c == LAT || c == 2 * LAT)) begin errors++; $display("FAIL b2b_r cyc %0d got %0b", c, r); end
      step();
    end
  endtask

  task automatic test_random();
    logic [15:0] a, d, rd, exp_mdr, exp_bus;
    logic        wr, word;
    logic [1:0]  exp_we;
    exp_mdr = mem_wdata;
    for (int t = 0; t < 40; t++) begin
      a = 16'($urandom); d = 16'($urandom); rd = 16'($urandom);
      wr = 1'($urandom); word = 1'($urandom);
      exp_we = !wr ? 2'b00 : (word ? 2'b11 : (a[0] ? 2'b10 : 2'b01));
      ld_mar = 1; addr_in = a; r_w = wr; data_size = word; bus_in = d; ld_mdr = wr; mio_en = 0;
      step();
      if (wr) exp_mdr = word ? d : (d & 16'h00FF) * 16'd257;
      ld_mar = 0; ld_mdr = 0; mio_en = 1;
      checks++; if (mar_out !== a || mem_addr !== a[15:1]) begin errors++; $display("FAIL rnd_mar t%0d got %h exp %h", t, mar_out, a); end
      checks++; if (mem_wdata !== exp_mdr) begin errors++; $display("FAIL rnd_mdr t%0d got %h exp %h", t, mem_wdata, exp_mdr); end
      step();
      if (TRAP_ON && word && a[0]) begin
        mio_en = 0;
        checks++; if (r !== 1'b1 || unaligned !== 1'b1 || mem_en !== 1'b0 || mem_we !== 2'b00) begin errors++; $display("FAIL rnd_trap t%0d got r=%0b u=%0b en=%0b we=%b", t, r, unaligned, mem_en, mem_we); end
        step();
      end else begin
        for (int c = 2; c <= LAT; c++) begin
          mio_en = (c == LAT) ? !wr : 1'($urandom);
          ld_mdr = (c == LAT) && !wr;
          mem_rdata = (c == LAT) ? rd : 16'($urandom);
          checks++; if (mem_en !== 1'b1 || r !== (c == LAT) || unaligned !== 1'b0) begin errors++; $display("FAIL rnd_cyc t%0d c%0d got en=%0b r=%0b", t, c, mem_en, r); end
          checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL rnd_we t%0d got %b exp %b", t, mem_we, exp_we); end
          step();
        end
        ld_mdr = 0; mio_en = 0;
        if (!wr) begin
          exp_mdr = rd;
          exp_bus = word ? rd : model_sext(a[0] ? rd[15:8] : rd[7:0]);
          #1;
          checks++; if (bus_out !== exp_bus) begin errors++; $display("FAIL rnd_bus t%0d got %h exp %h", t, bus_out, exp_bus); end
        end
      end
      checks++; if (mem_en !== 1'b0 || r !== 1'b0) begin errors++; $display("FAIL rnd_idle t%0d got en=%0b r=%0b", t, mem_en, r); end
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_byte_read();
    test_byte_write();
    test_freeze();
    test_reset_mid();
    test_unaligned();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
